// File: rtl/shift_add_multiplier_pkg.sv
// shift_add_multiplier_pkg: FSM state encoding and counter sizing shared by the multiplier files
package shift_add_multiplier_pkg;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_CALC = 2'd1,
        ST_DONE = 2'd2
    } state_t;

    function automatic int cnt_w(input int w);
        return (w < 2) ? 1 : $clog2(w);
    endfunction

endpackage

// File: rtl/shift_add_multiplier_adder_n.sv
// adder_n: WIDTH+WIDTH -> WIDTH+1 unsigned combinational adder with carry-out
module adder_n #(
    parameter int WIDTH = 4
) (
    input  logic [WIDTH-1:0] OperandoA,
    input  logic [WIDTH-1:0] OperandoB,
    output logic [WIDTH:0]   Soma
);

    assign Soma = {1'b0, OperandoA} + {1'b0, OperandoB};

endmodule

// File: rtl/shift_add_multiplier.sv
// shift_add_multiplier: unsigned shift-and-add multiplier, one partial product per clock
module shift_add_multiplier
    import shift_add_multiplier_pkg::*;
#(
    parameter int WIDTH = 4
) (
    input  logic               Clock,
    input  logic               Reset,
    input  logic               Start,
    input  logic [WIDTH-1:0]   OperandoA,
    input  logic [WIDTH-1:0]   OperandoB,
    output logic               Busy,
    output logic               Done,
    output logic [2*WIDTH-1:0] Produto
);

    localparam int CW = cnt_w(WIDTH);

    state_t             state_q, state_d;
    logic [WIDTH-1:0]   m_q, m_d;
    logic [2*WIDTH-1:0] p_q, p_d;
    logic [CW-1:0]      cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic               busy_q, busy_d;
    logic               done_q, done_d;
    logic [WIDTH:0]     sum;

    // P holds {partial, multiplier}; the adder carry shifts straight into the partial MSB
    adder_n #(.WIDTH(WIDTH)) u_adder (
        .OperandoA(p_q[2*WIDTH-1:WIDTH]),
        .OperandoB(p_q[0] ? m_q : '0),
        .Soma     (sum)
    );

    // next-state, datapath and registered-output decode
    always_comb begin
        state_d = state_q;
        m_d     = m_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        prod_d  = prod_q;
        case (state_q)
            ST_IDLE: if (Start) begin
                m_d     = OperandoA;
                p_d     = {{WIDTH{1'b0}}, OperandoB};
                cnt_d   = '0;
                state_d = ST_CALC;
            end
            ST_CALC: begin
                p_d   = {sum, p_q[WIDTH-1:1]};
                cnt_d = cnt_q + CW'(1);
                if (cnt_q == CW'(WIDTH - 1)) begin
                    prod_d  = p_d;
                    state_d = ST_DONE;
                end
            end
            default: state_d = ST_IDLE;
        endcase
        busy_d = (state_d == ST_CALC);
        done_d = (state_d == ST_DONE);
    end

    // state and output registers; reset discards any operation in flight
    always_ff @(posedge Clock or posedge Reset) begin
        if (Reset) begin
            state_q <= ST_IDLE;
            m_q     <= '0;
            p_q     <= '0;
            cnt_q   <= '0;
            prod_q  <= '0;
            busy_q  <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            m_q     <= m_d;
            p_q     <= p_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            busy_q  <= busy_d;
            done_q  <= done_d;
        end
    end

    assign Busy    = busy_q;
    assign Done    = done_q;
    assign Produto = prod_q;

endmodule

// File: tb/tb_shift_add_multiplier.sv
// tb_shift_add_multiplier: scoreboard bench for 4- and 8-bit multiplier instances
module tb_shift_add_multiplier;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic        start4 = 1'b0, start8 = 1'b0;
    logic [3:0]  a4 = '0, b4 = '0;
    logic [7:0]  a8 = '0, b8 = '0;
    logic        busy4, done4, busy8, done8;
    logic [7:0]  prod4;
    logic [15:0] prod8;

    int tests = 0;
    int failures = 0;
    logic [15:0] q4[$];
    logic [15:0] q8[$];
    logic [15:0] prev[2] = '{16'd0, 16'd0};

    shift_add_multiplier #(.WIDTH(4)) dut4 (
        .Clock(clk), .Reset(rst), .Start(start4), .OperandoA(a4), .OperandoB(b4),
        .Busy(busy4), .Done(done4), .Produto(prod4)
    );

    shift_add_multiplier #(.WIDTH(8)) dut8 (
        .Clock(clk), .Reset(rst), .Start(start8), .OperandoA(a8), .OperandoB(b8),
        .Busy(busy8), .Done(done8), .Produto(prod8)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    function automatic logic get_busy(input bit sel);
        return sel ? busy8 : busy4;
    endfunction

    function automatic logic get_done(input bit sel);
        return sel ? done8 : done4;
    endfunction

    function automatic logic [15:0] get_prod(input bit sel);
        return sel ? prod8 : {8'd0, prod4};
    endfunction

    task automatic drive(input bit sel, input logic s, input int unsigned a, input int unsigned b);
        if (sel) begin
            start8 = s; a8 = a[7:0]; b8 = b[7:0];
        end else begin
            start4 = s; a4 = a[3:0]; b4 = b[3:0];
        end
    endtask

    // Issue one operation at a negedge and follow it to the end of its Done pulse
    task automatic run_op(input bit sel, input int unsigned a, input int unsigned b, input bit hold_start);
        int unsigned mask, am, bm, w, nb, t;
        logic [15:0] hold;
        w    = sel ? 8 : 4;
        mask = sel ? 32'hFF : 32'hF;
        am   = a & mask;
        bm   = b & mask;
        hold = prev[sel];
        drive(sel, 1'b1, am, bm);
        if (sel) q8.push_back(16'(am * bm)); else q4.push_back(16'(am * bm));
        @(negedge clk);
        nb = 0;
        t  = 0;
        while (!get_done(sel) && t < 40) begin
            drive(sel, hold_start, $urandom, $urandom);
            if (get_busy(sel)) nb++;
            check("prod_hold", get_prod(sel), hold);
            t++;
            @(negedge clk);
        end
        check("done_seen", get_done(sel), 1);
        check("busy_cycles", nb, w);
        prev[sel] = 16'(am * bm);
        @(negedge clk);
        drive(sel, 1'b0, $urandom, $urandom);
        check("done_pulse", get_done(sel), 0);
        check("idle_after_done", get_busy(sel), 0);
        if (hold_start) begin
            @(negedge clk);
            check("no_queued_start", get_busy(sel), 0);
            check("result_kept", get_prod(sel), prev[sel]);
        end
    endtask

    // Scoreboard monitor for the 4-bit instance
    initial forever begin
        @(negedge clk);
        check("busy_done_excl4", busy4 & done4, 0);
        if (done4) begin
            if (q4.size() == 0) check("unexpected_done4", done4, 0);
            else check("prod4", {8'd0, prod4}, q4.pop_front());
        end
    end

    // Scoreboard monitor for the 8-bit instance
    initial forever begin
        @(negedge clk);
        check("busy_done_excl8", busy8 & done8, 0);
        if (done8) begin
            if (q8.size() == 0) check("unexpected_done8", done8, 0);
            else check("prod8", prod8, q8.pop_front());
        end
    end

    initial begin
        #5_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        repeat (2) @(negedge clk);
        check("reset_busy", busy4, 0);
        check("reset_done", done4, 0);
        check("reset_prod", {8'd0, prod4}, 0);
        check("reset_prod8", prod8, 0);
        rst = 1'b0;
        @(negedge clk);

        run_op(0, 3, 5, 0);
        run_op(0, 15, 15, 0);
        run_op(0, 15, 1, 0);
        run_op(0, 0, 9, 0);
        run_op(0, 7, 8, 1);

        drive(0, 1'b1, 9, 6);
        @(negedge clk);
        drive(0, 1'b0, 0, 0);
        @(negedge clk);
        #2 rst = 1'b1;
        #1;
        check("async_busy", busy4, 0);
        check("async_done", done4, 0);
        check("async_prod", {8'd0, prod4}, 0);
        prev[0] = '0;
        prev[1] = '0;
        @(negedge clk);
        rst = 1'b0;
        @(negedge clk);
        run_op(0, 9, 6, 0);

        run_op(0, 2, 3, 0);
        run_op(0, 4, 4, 0);
        for (int i = 0; i < 200; i++) run_op(0, $urandom, $urandom, 0);

        run_op(1, 255, 255, 0);
        run_op(1, 0, 0, 0);
        for (int i = 0; i < 1000; i++) run_op(1, $urandom, $urandom, 0);

        repeat (3) @(negedge clk);
        check("q4_drained", q4.size(), 0);
        check("q8_drained", q8.size(), 0);
        $display("[TB] %0d tests run, %0d failed", tests, failures);
        $finish;
    end

endmodule
